// File: rtl/vote_link_ctrl.sv
// Voter link controller: collects a parity-protected vote word from toggle buttons and
// exchanges it with a peer over rts/rtr/cts/ctr, with timeouts, a round limit and sticky error.
module vote_link_ctrl #(
    parameter  int NBTN       = 2,
    parameter  int TO_CYC     = 16,
    parameter  int MAX_ROUNDS = 8,
    localparam int W          = NBTN + 2,
    localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          key,
    input  logic [NBTN-1:0] btn,
    input  logic          rts,
    input  logic          rtr,
    input  logic [W-1:0]  v_in,
    output logic          cts,
    output logic          ctr,
    output logic [W-1:0]  v_out,
    output logic          busy,
    output logic          err,
    output logic [RW-1:0] rounds
);

    localparam int TW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
    localparam logic [W-1:0] END_CODE = {1'(NBTN % 2), {NBTN{1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        ST_STANDBY  = 4'd0,
        ST_COLLECT  = 4'd1,
        ST_START_TX = 4'd2,
        ST_SEND     = 4'd3,
        ST_TX_2_RX  = 4'd4,
        ST_RECEIVE  = 4'd5,
        ST_RX_2_TX  = 4'd6,
        ST_END_TX   = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    vote, vote_n;
    logic [NBTN-1:0] last_btn, last_btn_n;
    logic [TW-1:0]   timer, timer_n;
    logic [RW-1:0]   rounds_n;
    logic [W-1:0]    v_out_n;
    logic            cts_n, ctr_n, err_n;
    logic            timed, tmo;

    assign busy = (state != ST_STANDBY) && (state != ST_ERROR);
    assign tmo  = (TO_CYC > 0) && (timer == TW'(TO_CYC - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_STANDBY;
            vote     <= '0;
            last_btn <= '0;
            timer    <= '0;
            rounds   <= '0;
            v_out    <= '0;
            cts      <= 1'b0;
            ctr      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            vote     <= vote_n;
            last_btn <= last_btn_n;
            timer    <= timer_n;
            rounds   <= rounds_n;
            v_out    <= v_out_n;
            cts      <= cts_n;
            ctr      <= ctr_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        vote_n     = vote;
        last_btn_n = last_btn;
        rounds_n   = rounds;
        v_out_n    = v_out;
        cts_n      = cts;
        ctr_n      = ctr;
        err_n      = err;
        timed      = 1'b0;

        case (state)
            ST_STANDBY: begin
                cts_n = rtr;
                if (start) begin
                    vote_n  = '0;
                    state_n = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!start) begin
                    state_n = ST_START_TX;
                end else if (key) begin
                    vote_n[0] = 1'b1;
                    for (int i = 0; i < NBTN; i++) begin
                        if (btn[i] && !last_btn[i]) vote_n[i+1] = ~vote[i+1];
                    end
                    last_btn_n = btn;
                end else begin
                    vote_n = '0;
                end
            end
            ST_START_TX: begin
                vote_n[W-1] = ^vote[W-2:0];
                rounds_n    = '0;
                state_n     = ST_SEND;
            end
            ST_SEND: begin
                if (rtr) begin
                    v_out_n  = vote;
                    cts_n    = 1'b1;
                    rounds_n = rounds + RW'(1);
                    if (vote == END_CODE)                     state_n = ST_END_TX;
                    else if (rounds == RW'(MAX_ROUNDS - 1))   state_n = ST_ERROR;
                    else                                      state_n = ST_TX_2_RX;
                end
            end
            ST_TX_2_RX: begin
                timed = 1'b1;
                if (!rts) begin
                    ctr_n   = 1'b1;
                    state_n = ST_RECEIVE;
                end else if (tmo) begin
                    state_n = ST_ERROR;
                end
            end
            ST_RECEIVE: begin
                timed = 1'b1;
                if (rts) begin
                    ctr_n = 1'b0;
                    if (^v_in == 1'b0) begin
                        vote_n  = v_in;
                        state_n = ST_RX_2_TX;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else if (tmo) begin
                    state_n = ST_ERROR;
                end
            end
            ST_RX_2_TX: begin
                timed = 1'b1;
                if (!rtr) begin
                    cts_n   = 1'b0;
                    state_n = ST_SEND;
                end else if (tmo) begin
                    state_n = ST_ERROR;
                end
            end
            ST_END_TX: begin
                timed = 1'b1;
                if (!rtr) begin
                    cts_n   = 1'b0;
                    state_n = ST_STANDBY;
                end else if (tmo) begin
                    state_n = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (start) begin
                    err_n    = 1'b0;
                    rounds_n = '0;
                    state_n  = ST_STANDBY;
                end
            end
            default: state_n = ST_STANDBY;
        endcase

        // Any path into ERROR drops both handshake lines, overriding a same-cycle SEND commit.
        if (state_n == ST_ERROR && state != ST_ERROR) begin
            err_n = 1'b1;
            cts_n = 1'b0;
            ctr_n = 1'b0;
        end

        // Timer only runs while parked in a wait state; leaving at TO_CYC-1 keeps it from wrapping.
        if (TO_CYC == 0 || !timed || state_n != state) timer_n = '0;
        else                                             timer_n = timer + TW'(1);
    end

endmodule

// File: tb/tb_vote_link_ctrl.sv
// Bench for vote_link_ctrl: per-cycle vector records through a scoreboard queue,
// main peer loop as a table plus hand sequences for parity, reset, timeout and round limit.
module tb_vote_link_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       key   = 1'b0;
    logic [1:0] btn   = '0;
    logic       rts   = 1'b0;
    logic       rtr   = 1'b0;
    logic [3:0] v_in  = '0;

    logic       cts, ctr, busy, err;
    logic [3:0] v_out, rounds;
    logic       cts2, ctr2, busy2, err2;
    logic [3:0] v_out2;
    logic [1:0] rounds2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    vote_link_ctrl #(.NBTN(2), .TO_CYC(16), .MAX_ROUNDS(8)) dut (
        .clock(clock), .reset(reset), .start(start), .key(key), .btn(btn),
        .rts(rts), .rtr(rtr), .v_in(v_in),
        .cts(cts), .ctr(ctr), .v_out(v_out), .busy(busy), .err(err), .rounds(rounds)
    );

    vote_link_ctrl #(.NBTN(2), .TO_CYC(16), .MAX_ROUNDS(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .key(key), .btn(btn),
        .rts(rts), .rtr(rtr), .v_in(v_in),
        .cts(cts2), .ctr(ctr2), .v_out(v_out2), .busy(busy2), .err(err2), .rounds(rounds2)
    );

    typedef struct packed {
        logic       rst, start, key;
        logic [1:0] btn;
        logic       rts, rtr;
        logic [3:0] vin;
        logic       chk2;
        logic       cts, ctr;
        logic [3:0] vout;
        logic       busy, err;
        logic [3:0] rounds;
    } vec_t;

    vec_t exp_q[$];

    function automatic vec_t mk(input int rst, st, k, b, rs, rr, vi, c2,
                                input int e_cts, e_ctr, e_vo, e_busy, e_err, e_rnd);
        vec_t v;
        v.rst = 1'(rst);  v.start = 1'(st); v.key = 1'(k);  v.btn = 2'(b);
        v.rts = 1'(rs);   v.rtr = 1'(rr);   v.vin = 4'(vi); v.chk2 = 1'(c2);
        v.cts = 1'(e_cts); v.ctr = 1'(e_ctr); v.vout = 4'(e_vo);
        v.busy = 1'(e_busy); v.err = 1'(e_err); v.rounds = 4'(e_rnd);
        return v;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare just after the edge.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        logic [11:0] act, exp;
        reset = v.rst; start = v.start; key = v.key; btn = v.btn;
        rts = v.rts; rtr = v.rtr; v_in = v.vin;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        exp = {e.cts, e.ctr, e.vout, e.busy, e.err, e.rounds};
        if (e.chk2) act = {cts2, ctr2, v_out2, busy2, err2, {2'b00, rounds2}};
        else        act = {cts, ctr, v_out, busy, err, rounds};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cts,ctr,vout,busy,err,rounds=%b,%b,%h,%b,%b,%0d want %b,%b,%h,%b,%b,%0d",
                     nm, act[11], act[10], act[9:6], act[5], act[4], act[3:0],
                     exp[11], exp[10], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Reset, collect a key-only vote (word 1001), commit it; ends in TX_2_RX with rts=rtr=1.
    task automatic to_tx2rx(input int c2);
        step(mk(1,0,0,0,0,0,0,c2, 0,0,0,0,0,0), "pre_rst");
        step(mk(0,1,0,0,0,0,0,c2, 0,0,0,1,0,0), "pre_coll");
        step(mk(0,1,1,0,0,0,0,c2, 0,0,0,1,0,0), "pre_key");
        step(mk(0,0,0,0,0,0,0,c2, 0,0,0,1,0,0), "pre_sttx");
        step(mk(0,0,0,0,0,1,0,c2, 0,0,0,1,0,0), "pre_send");
        step(mk(0,0,0,0,1,1,0,c2, 1,0,9,1,0,1), "pre_commit");
    endtask

    vec_t tbl[19];

    initial begin
        //            rst st k btn rts rtr vin c2 | cts ctr vout busy err rnd
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 1, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 1, 1, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 3, 1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 3, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 3, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 6, 0,   1, 0, 3, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 3, 1, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 3, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 6, 1, 0, 2);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 6, 1, 0, 2);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 6, 0, 0, 2);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 6, 0, 0, 2);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 6, 0, 0, 2);

        step(mk(1,0,0,0,0,1,0,0, 0,0,0,0,0,0), "reset_state");
        for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("loop%0d", i));

        // Odd-parity word from the peer is fatal; start clears the error.
        to_tx2rx(0);
        step(mk(0,0,0,0,0,1,0,0, 1,1,9,1,0,1), "par_recv");
        step(mk(0,0,0,0,1,1,7,0, 0,0,9,0,1,1), "par_err");
        step(mk(0,0,0,0,0,1,0,0, 0,0,9,0,1,1), "par_sticky");
        step(mk(0,1,0,0,0,1,0,0, 0,0,9,0,0,0), "par_clear");
        step(mk(0,0,0,0,0,1,0,0, 1,0,9,0,0,0), "par_standby");

        // Reset in the middle of RECEIVE with ctr high.
        to_tx2rx(0);
        step(mk(0,0,0,0,0,1,0,0, 1,1,9,1,0,1), "rst_recv");
        step(mk(1,1,1,3,1,1,0,0, 0,0,0,0,0,0), "rst_mid");

        // Peer never drops rts: ERROR exactly 16 cycles after TX_2_RX entry.
        to_tx2rx(0);
        for (int k = 1; k <= 15; k++)
            step(mk(0,0,0,0,1,1,0,0, 1,0,9,1,0,1), $sformatf("to_wait%0d", k));
        step(mk(0,0,0,0,1,1,0,0, 0,0,9,0,1,1), "to_err16");

        // Exit condition on the last allowed cycle beats the timeout.
        to_tx2rx(0);
        for (int k = 1; k <= 15; k++)
            step(mk(0,0,0,0,1,1,0,0, 1,0,9,1,0,1), $sformatf("to2_wait%0d", k));
        step(mk(0,0,0,0,0,1,0,0, 1,1,9,1,0,1), "to2_exit16");
        step(mk(0,0,0,0,0,1,0,0, 1,1,9,1,0,1), "to2_noerr");

        // Round limit of 2 on the second instance: peer keeps returning 0011.
        to_tx2rx(1);
        step(mk(0,0,0,0,0,1,0,1, 1,1,9,1,0,1), "rl_recv");
        step(mk(0,0,0,0,1,1,3,1, 1,0,9,1,0,1), "rl_rx2tx");
        step(mk(0,0,0,0,1,0,0,1, 0,0,9,1,0,1), "rl_send");
        step(mk(0,0,0,0,1,1,0,1, 0,0,3,0,1,2), "rl_limit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
